// File: rtl/uart_rx_packet_ctrl_if.sv
// Receiver-side and buffer-side signal bundle for the packet loader.
// master: the packet controller. slave: the receiver/buffer/host environment.
interface uart_rx_packet_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_WIDTH = 10
);
  // host control
  logic                             enable;
  logic [ADDR_WIDTH-1:0]            base_addr;
  // byte receiver
  logic [DATA_WIDTH-1:0]            rx_data;
  logic                             rx_done;
  logic                             rx_en;
  // on-chip buffer write port
  logic                             mem_we;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [DATA_WIDTH*WORD_BYTES-1:0] mem_wdata;
  // packet status
  logic                             busy;
  logic                             pkt_ok;
  logic                             pkt_err;
  logic [7:0]                       words_written;

  modport master (
    input  enable, base_addr, rx_data, rx_done,
    output rx_en, mem_we, mem_addr, mem_wdata, busy, pkt_ok, pkt_err, words_written
  );

  modport slave (
    output enable, base_addr, rx_data, rx_done,
    input  rx_en, mem_we, mem_addr, mem_wdata, busy, pkt_ok, pkt_err, words_written
  );
endinterface

// File: rtl/uart_rx_packet_ctrl.sv
// Packet loader: parses SYNC / LEN / payload / checksum frames from a byte
// receiver, packs payload bytes little-endian into buffer words and reports
// the outcome of each packet with one-cycle status pulses.
module uart_rx_packet_ctrl #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    WORD_BYTES     = 2,   // 1..4
  parameter int                    ADDR_WIDTH     = 10,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = 8'hA5,
  parameter int                    TIMEOUT_CYCLES = 1000000  // must be >= 2
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  uart_rx_packet_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DONE
  } state_t;

  localparam int WORD_WIDTH = DATA_WIDTH * WORD_BYTES;
  localparam int TO_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);
  // The counter reads 0 in the cycle after a byte, so expiring at T-2 puts the
  // error pulse exactly TIMEOUT_CYCLES cycles after the last received byte.
  localparam logic [TO_WIDTH-1:0] TO_EXPIRE = TO_WIDTH'(TIMEOUT_CYCLES - 2);
  localparam logic [1:0]          LAST_LANE = 2'(WORD_BYTES - 1);

  state_t                                 state_reg, state_next;
  logic [ADDR_WIDTH-1:0]                  base_reg, base_next;
  logic [7:0]                             len_reg, len_next;
  logic [DATA_WIDTH-1:0]                  csum_reg, csum_next;
  logic [1:0]                             byte_idx_reg, byte_idx_next;
  logic [7:0]                             word_idx_reg, word_idx_next;
  logic [TO_WIDTH-1:0]                    timeout_cnt_reg, timeout_cnt_next;
  logic [WORD_BYTES-1:0][DATA_WIDTH-1:0]  lanes_reg, lanes_next;
  logic [WORD_BYTES-1:0][DATA_WIDTH-1:0]  lanes_upd;

  logic                                   rx_en_reg, rx_en_next;
  logic                                   mem_we_reg, mem_we_next;
  logic [ADDR_WIDTH-1:0]                  mem_addr_reg, mem_addr_next;
  logic [WORD_WIDTH-1:0]                  mem_wdata_reg, mem_wdata_next;
  logic                                   busy_reg, busy_next;
  logic                                   pkt_ok_reg, pkt_ok_next;
  logic                                   pkt_err_reg, pkt_err_next;
  logic [7:0]                             words_written_reg, words_written_next;

  logic                                   in_packet;
  logic                                   timeout_hit;
  logic                                   abort_pkt;

  // Word being assembled with the incoming byte dropped into lane byte_idx.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign lanes_upd[gi] = (byte_idx_reg == 2'(gi)) ? bus.rx_data : lanes_reg[gi];
    end
  endgenerate

  assign in_packet   = (state_reg == ST_LEN) || (state_reg == ST_PAYLOAD) ||
                       (state_reg == ST_CSUM);
  assign timeout_hit = (timeout_cnt_reg == TO_EXPIRE);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign abort_pkt   = in_packet && (!bus.enable || (!bus.rx_done && timeout_hit));

  // Next-state and datapath decisions for the frame parser.
  always_comb begin
    state_next         = state_reg;
    base_next          = base_reg;
    len_next           = len_reg;
    csum_next          = csum_reg;
    byte_idx_next      = byte_idx_reg;
    word_idx_next      = word_idx_reg;
    lanes_next         = lanes_reg;
    timeout_cnt_next   = '0;
    rx_en_next         = bus.enable;
    mem_we_next        = 1'b0;
    mem_addr_next      = mem_addr_reg;
    mem_wdata_next     = mem_wdata_reg;
    busy_next          = busy_reg;
    pkt_ok_next        = 1'b0;
    pkt_err_next       = 1'b0;
    words_written_next = words_written_reg;

    if (in_packet && !bus.rx_done) begin
      timeout_cnt_next = timeout_cnt_reg + 1'b1;
    end

    if (abort_pkt) begin
      state_next   = ST_DONE;
      pkt_err_next = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.rx_done && (bus.rx_data == SYNC_BYTE)) begin
            state_next         = ST_LEN;
            base_next          = bus.base_addr;
            csum_next          = '0;
            byte_idx_next      = '0;
            word_idx_next      = '0;
            words_written_next = '0;
            busy_next          = 1'b1;
          end
        end

        ST_LEN: begin
          if (bus.rx_done) begin
            len_next = 8'(bus.rx_data);
            if (bus.rx_data == '0) begin
              state_next   = ST_DONE;
              pkt_err_next = 1'b1;
            end else begin
              state_next = ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (bus.rx_done) begin
            lanes_next = lanes_upd;
            csum_next  = csum_reg + bus.rx_data;
            if (byte_idx_reg == LAST_LANE) begin
              mem_we_next        = 1'b1;
              mem_addr_next      = base_reg + ADDR_WIDTH'(word_idx_reg);
              mem_wdata_next     = lanes_upd;
              byte_idx_next      = '0;
              word_idx_next      = word_idx_reg + 8'd1;
              words_written_next = words_written_reg + 8'd1;
              if (word_idx_reg == (len_reg - 8'd1)) begin
                state_next = ST_CSUM;
              end
            end else begin
              byte_idx_next = byte_idx_reg + 2'd1;
            end
          end
        end

        ST_CSUM: begin
          if (bus.rx_done) begin
            state_next = ST_DONE;
            if (bus.rx_data == csum_reg) begin
              pkt_ok_next = 1'b1;
            end else begin
              pkt_err_next = 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Status pulse is on the outputs this cycle; bytes are ignored.
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end

        default: begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset abandons any packet in flight silently.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg         <= ST_IDLE;
      base_reg          <= '0;
      len_reg           <= '0;
      csum_reg          <= '0;
      byte_idx_reg      <= '0;
      word_idx_reg      <= '0;
      timeout_cnt_reg   <= '0;
      lanes_reg         <= '0;
      rx_en_reg         <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= '0;
      mem_wdata_reg     <= '0;
      busy_reg          <= 1'b0;
      pkt_ok_reg        <= 1'b0;
      pkt_err_reg       <= 1'b0;
      words_written_reg <= '0;
    end else begin
      state_reg         <= state_next;
      base_reg          <= base_next;
      len_reg           <= len_next;
      csum_reg          <= csum_next;
      byte_idx_reg      <= byte_idx_next;
      word_idx_reg      <= word_idx_next;
      timeout_cnt_reg   <= timeout_cnt_next;
      lanes_reg         <= lanes_next;
      rx_en_reg         <= rx_en_next;
      mem_we_reg        <= mem_we_next;
      mem_addr_reg      <= mem_addr_next;
      mem_wdata_reg     <= mem_wdata_next;
      busy_reg          <= busy_next;
      pkt_ok_reg        <= pkt_ok_next;
      pkt_err_reg       <= pkt_err_next;
      words_written_reg <= words_written_next;
    end
  end

  assign bus.rx_en         = rx_en_reg;
  assign bus.mem_we        = mem_we_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.mem_wdata     = mem_wdata_reg;
  assign bus.busy          = busy_reg;
  assign bus.pkt_ok        = pkt_ok_reg;
  assign bus.pkt_err       = pkt_err_reg;
  assign bus.words_written = words_written_reg;

endmodule
